// File: rtl/lcd_addr_pkg.sv
// Shared types and geometry constants for the LCD frame-buffer address path.
// The optional bottom-up scan is controlled by LCD_ADDR_GEN_FLIP_Y_EN in the generator.
package lcd_addr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } lcd_state_e;

    localparam int unsigned LCD_ADDR_WIDTH = 17;
    localparam int unsigned LCD_XW         = 9;
    localparam int unsigned LCD_YW         = 9;

    // Default panel window, also consumed by the LCD transfer FSM
    localparam int unsigned LCD_PANEL_BASE   = 108;
    localparam int unsigned LCD_PANEL_WIDTH  = 320;
    localparam int unsigned LCD_PANEL_HEIGHT = 240;

endpackage : lcd_addr_pkg

// File: rtl/lcd_axis_counter.sv
// Wrapping axis counter: counts 0..limit_i, clears on clr_i, flags its terminal value.
module lcd_axis_counter #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] limit_i,
    output logic         term_c_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign term_c_o = (cnt_q == limit_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = term_c_o ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : lcd_axis_counter

// File: rtl/lcd_window_addr_gen.sv
// Rectangular-window frame-buffer address walker with line/frame terminal flags.
// Optional bottom-up line order via LCD_ADDR_GEN_FLIP_Y_EN (adds flip_i).
module lcd_window_addr_gen
    import lcd_addr_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = LCD_ADDR_WIDTH,
    parameter int unsigned XW         = LCD_XW,
    parameter int unsigned YW         = LCD_YW
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  continuous_i,
`ifdef LCD_ADDR_GEN_FLIP_Y_EN
    input  logic                  flip_i,
`endif
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [XW-1:0]         width_i,
    input  logic [YW-1:0]         height_i,
    input  logic [ADDR_WIDTH-1:0] stride_i,
    input  logic                  cnt_en_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  busy_o,
    output logic                  line_end_o,
    output logic                  frame_end_o,
    output logic                  done_o
);

    lcd_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] line_base_q, line_base_d;
    logic [ADDR_WIDTH-1:0] origin_q, origin_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [XW-1:0]         width_q, width_d;
    logic [YW-1:0]         height_q, height_d;
    logic                  cont_q, cont_d;
    logic                  done_q, done_d;

    logic                  run, start_ok, step, x_term, y_term;
    logic [ADDR_WIDTH-1:0] start_addr, next_line;

    assign run      = (state_q == RUN);
    assign start_ok = (state_q == IDLE) & start_i & ~stop_i & (|width_i) & (|height_i);
    assign step     = run & cnt_en_i & ~stop_i;

`ifdef LCD_ADDR_GEN_FLIP_Y_EN
    logic flip_q, flip_d;

    // Bottom-up scan starts on the last line and walks the stride backwards
    assign start_addr = flip_i
        ? base_addr_i + ADDR_WIDTH'(ADDR_WIDTH'(height_i - YW'(1)) * stride_i)
        : base_addr_i;
    assign next_line  = flip_q ? line_base_q - stride_q : line_base_q + stride_q;
`else
    assign start_addr = base_addr_i;
    assign next_line  = line_base_q + stride_q;
`endif

    lcd_axis_counter #(.W(XW)) u_x_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .en_i     (step),
        .clr_i    (start_ok | stop_i),
        .limit_i  (width_q - XW'(1)),
        .term_c_o (x_term)
    );

    lcd_axis_counter #(.W(YW)) u_y_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .en_i     (step & x_term),
        .clr_i    (start_ok | stop_i),
        .limit_i  (height_q - YW'(1)),
        .term_c_o (y_term)
    );

    assign addr_o      = addr_q;
    assign busy_o      = run;
    assign line_end_o  = run & x_term;
    assign frame_end_o = run & x_term & y_term;
    assign done_o      = done_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        line_base_d = line_base_q;
        origin_d    = origin_q;
        stride_d    = stride_q;
        width_d     = width_q;
        height_d    = height_q;
        cont_d      = cont_q;
        done_d      = 1'b0;
`ifdef LCD_ADDR_GEN_FLIP_Y_EN
        flip_d      = flip_q;
`endif
        if (stop_i) begin
            state_d = IDLE;
        end else if (start_ok) begin
            state_d     = RUN;
            addr_d      = start_addr;
            line_base_d = start_addr;
            origin_d    = start_addr;
            stride_d    = stride_i;
            width_d     = width_i;
            height_d    = height_i;
            cont_d      = continuous_i;
`ifdef LCD_ADDR_GEN_FLIP_Y_EN
            flip_d      = flip_i;
`endif
        end else if (step) begin
            if (!x_term) begin
                addr_d = addr_q + ADDR_WIDTH'(1);
            end else if (!y_term) begin
                line_base_d = next_line;
                addr_d      = next_line;
            end else if (cont_q) begin
                line_base_d = origin_q;
                addr_d      = origin_q;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            line_base_q <= '0;
            origin_q    <= '0;
            stride_q    <= '0;
            width_q     <= '0;
            height_q    <= '0;
            cont_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef LCD_ADDR_GEN_FLIP_Y_EN
            flip_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            line_base_q <= line_base_d;
            origin_q    <= origin_d;
            stride_q    <= stride_d;
            width_q     <= width_d;
            height_q    <= height_d;
            cont_q      <= cont_d;
            done_q      <= done_d;
`ifdef LCD_ADDR_GEN_FLIP_Y_EN
            flip_q      <= flip_d;
`endif
        end
    end

endmodule : lcd_window_addr_gen

// File: tb/tb_lcd_window_addr_gen.sv
// Self-checking bench for lcd_window_addr_gen: frame-list model plus directed vectors.
module tb_lcd_window_addr_gen;

    localparam int unsigned AW = 17;

    logic          clk;
    logic          rstn;
    logic          start_i, stop_i, continuous_i, cnt_en_i;
    logic [AW-1:0] base_addr_i, stride_i;
    logic [8:0]    width_i, height_i;
    logic [AW-1:0] addr_o;
    logic          busy_o, line_end_o, frame_end_o, done_o;
`ifdef LCD_ADDR_GEN_FLIP_Y_EN
    logic          flip_i;
`endif

    int errors = 0;
    int checks = 0;

    lcd_window_addr_gen dut (
        .clk          (clk),
        .rstn         (rstn),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .continuous_i (continuous_i),
`ifdef LCD_ADDR_GEN_FLIP_Y_EN
        .flip_i       (flip_i),
`endif
        .base_addr_i  (base_addr_i),
        .width_i      (width_i),
        .height_i     (height_i),
        .stride_i     (stride_i),
        .cnt_en_i     (cnt_en_i),
        .addr_o       (addr_o),
        .busy_o       (busy_o),
        .line_end_o   (line_end_o),
        .frame_end_o  (frame_end_o),
        .done_o       (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the frame is a list of addresses; an index walks it
    logic [AW-1:0] m_list[$];
    logic [AW-1:0] m_addr = '0;
    bit            m_busy = 1'b0;
    bit            m_done = 1'b0;
    bit            m_cont = 1'b0;
    bit            m_flip = 1'b0;
    int            m_idx  = 0;
    int            m_w    = 0;
    int            m_h    = 0;

    initial forever begin
        @(posedge clk or negedge rstn);
        if (!rstn) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_addr = '0;
            m_idx  = 0;
        end else begin
            m_done = 1'b0;
            if (stop_i) begin
                m_busy = 1'b0;
            end else if (!m_busy && start_i && width_i != 0 && height_i != 0) begin
                m_w    = int'(width_i);
                m_h    = int'(height_i);
                m_cont = continuous_i;
`ifdef LCD_ADDR_GEN_FLIP_Y_EN
                m_flip = flip_i;
`else
                m_flip = 1'b0;
`endif
                m_list.delete();
                for (int y = 0; y < m_h; y++) begin
                    for (int x = 0; x < m_w; x++) begin
                        int unsigned row;
                        int unsigned t;
                        row = m_flip ? int'(m_h - 1 - y) : y;
                        t   = int'(base_addr_i) + row * int'(stride_i) + x;
                        m_list.push_back(AW'(t));
                    end
                end
                m_idx  = 0;
                m_busy = 1'b1;
                m_addr = m_list[0];
            end else if (m_busy && cnt_en_i) begin
                if (m_idx == m_w * m_h - 1) begin
                    if (m_cont) begin
                        m_idx  = 0;
                        m_addr = m_list[0];
                    end else begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end
                end else begin
                    m_idx++;
                    m_addr = m_list[m_idx];
                end
            end
        end
    end

    // Compare every cycle, away from the active edge
    initial forever begin
        bit exp_le, exp_fe;
        @(negedge clk);
        exp_le = 1'b0;
        exp_fe = 1'b0;
        if (m_busy) begin
            exp_le = ((m_idx % m_w) == m_w - 1);
            exp_fe = (m_idx == m_w * m_h - 1);
        end
        chk("model_addr",      32'(addr_o),      32'(m_addr));
        chk("model_busy",      32'(busy_o),      32'(m_busy));
        chk("model_line_end",  32'(line_end_o),  32'(exp_le));
        chk("model_frame_end", 32'(frame_end_o), 32'(exp_fe));
        chk("model_done",      32'(done_o),      32'(m_done));
    end

    logic [AW-1:0] cap_a[$], cap_le[$], cap_fe[$];
    int unsigned   eq[$];

    task automatic start_frame(input int unsigned b, input int unsigned w, input int unsigned h,
                               input int unsigned s, input bit c);
        @(negedge clk);
        base_addr_i  = AW'(b);
        width_i      = 9'(w);
        height_i     = 9'(h);
        stride_i     = AW'(s);
        continuous_i = c;
        start_i      = 1'b1;
        @(negedge clk);
        start_i      = 1'b0;
    endtask

    // Records outputs while busy; bounded so a stuck DUT cannot hang the run
    task automatic capture(input int maxc);
        int n;
        n = 0;
        cap_a.delete();
        cap_le.delete();
        cap_fe.delete();
        while (busy_o && n < maxc) begin
            cap_a.push_back(addr_o);
            if (line_end_o)  cap_le.push_back(addr_o);
            if (frame_end_o) cap_fe.push_back(addr_o);
            @(negedge clk);
            n++;
        end
        chk("capture_busy_dropped", 32'(busy_o), 32'd0);
    endtask

    task automatic check_seq(input string nm, input int unsigned exp_q[$], input logic [AW-1:0] got_q[$]);
        chk({nm, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk(nm, 32'(got_q[i]), exp_q[i]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned frame[$];
        bit          busy_all;
        int          n;

        rstn = 1'b0;
        start_i = 1'b0; stop_i = 1'b0; continuous_i = 1'b0; cnt_en_i = 1'b1;
        base_addr_i = '0; stride_i = '0; width_i = '0; height_i = '0;
`ifdef LCD_ADDR_GEN_FLIP_Y_EN
        flip_i = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        chk("reset_addr",      32'(addr_o),      32'd0);
        chk("reset_busy",      32'(busy_o),      32'd0);
        chk("reset_line_end",  32'(line_end_o),  32'd0);
        chk("reset_frame_end", 32'(frame_end_o), 32'd0);
        chk("reset_done",      32'(done_o),      32'd0);
        rstn = 1'b1;

        // Single-shot 4x3 window
        start_frame(108, 4, 3, 10, 1'b0);
        capture(40);
        chk("ss_done_pulse", 32'(done_o), 32'd1);
        frame = '{108, 109, 110, 111, 118, 119, 120, 121, 128, 129, 130, 131};
        check_seq("ss_addr", frame, cap_a);
        eq = '{111, 121, 131};
        check_seq("ss_line_end", eq, cap_le);
        eq = '{131};
        check_seq("ss_frame_end", eq, cap_fe);
        @(negedge clk);
        chk("ss_done_one_cycle", 32'(done_o), 32'd0);
        chk("ss_addr_hold",      32'(addr_o), 32'd131);

        // Continuous: three frames back to back, start during RUN ignored
        start_frame(108, 4, 3, 10, 1'b1);
        busy_all = 1'b1;
        cap_a.delete();
        for (int i = 0; i < 36; i++) begin
            cap_a.push_back(addr_o);
            if (!busy_o) busy_all = 1'b0;
            if (i == 5) begin
                start_i = 1'b1;
                width_i = 9'd7;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk);
        end
        width_i = 9'd4;
        chk("cont_busy_all", 32'(busy_all), 32'd1);
        eq.delete();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 12; i++) eq.push_back(frame[i]);
        end
        check_seq("cont_addr", eq, cap_a);
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
        chk("cont_stop_busy", 32'(busy_o), 32'd0);
        chk("cont_stop_done", 32'(done_o), 32'd0);
        chk("cont_stop_addr", 32'(addr_o), 32'd108);

        // Enable toggling, then stop at 119
        start_frame(108, 4, 3, 10, 1'b0);
        n = 0;
        while (addr_o != AW'(118) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("en_reach_118", 32'(addr_o), 32'd118);
        cnt_en_i = 1'b1;
        @(negedge clk);
        chk("en_step_119", 32'(addr_o), 32'd119);
        cnt_en_i = 1'b0;
        @(negedge clk);
        chk("en_hold_a", 32'(addr_o), 32'd119);
        @(negedge clk);
        chk("en_hold_b", 32'(addr_o), 32'd119);
        cnt_en_i = 1'b1;
        stop_i   = 1'b1;
        @(negedge clk);
        stop_i   = 1'b0;
        chk("stop_busy", 32'(busy_o), 32'd0);
        chk("stop_addr", 32'(addr_o), 32'd119);
        chk("stop_done", 32'(done_o), 32'd0);

        // Zero dimensions and stop-over-start are ignored
        start_frame(200, 0, 3, 10, 1'b0);
        chk("zero_w_busy", 32'(busy_o), 32'd0);
        chk("zero_w_addr", 32'(addr_o), 32'd119);
        start_frame(200, 4, 0, 10, 1'b0);
        chk("zero_h_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        width_i = 9'd4; height_i = 9'd3; start_i = 1'b1; stop_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; stop_i = 1'b0;
        chk("stop_beats_start", 32'(busy_o), 32'd0);

        // 1x1 window
        start_frame(300, 1, 1, 10, 1'b0);
        chk("one_addr",      32'(addr_o),      32'd300);
        chk("one_line_end",  32'(line_end_o),  32'd1);
        chk("one_frame_end", 32'(frame_end_o), 32'd1);
        @(negedge clk);
        chk("one_busy_off",  32'(busy_o),      32'd0);
        chk("one_done",      32'(done_o),      32'd1);
        chk("one_fe_off",    32'(frame_end_o), 32'd0);

        // Address wrap at 2^17
        start_frame(131070, 4, 1, 0, 1'b0);
        capture(20);
        chk("wrap_done", 32'(done_o), 32'd1);
        eq = '{131070, 131071, 0, 1};
        check_seq("wrap_addr", eq, cap_a);

`ifdef LCD_ADDR_GEN_FLIP_Y_EN
        flip_i = 1'b1;
        start_frame(108, 2, 3, 10, 1'b0);
        flip_i = 1'b0;
        capture(20);
        eq = '{128, 129, 118, 119, 108, 109};
        check_seq("flip_addr", eq, cap_a);
`endif

        // Asynchronous reset in the middle of a line
        start_frame(108, 4, 3, 10, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_addr", 32'(addr_o), 32'd110);
        #2 rstn = 1'b0;
        #1;
        chk("areset_addr",      32'(addr_o),      32'd0);
        chk("areset_busy",      32'(busy_o),      32'd0);
        chk("areset_line_end",  32'(line_end_o),  32'd0);
        chk("areset_frame_end", 32'(frame_end_o), 32'd0);
        chk("areset_done",      32'(done_o),      32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_reset_busy", 32'(busy_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_lcd_window_addr_gen
